// File: rtl/rename_freelist_if.sv
// Rename free-list port bundle: rename-group allocation, commit-time release and squash.
// The master side (rename/commit logic) drives the i_* signals; the free list drives o_*.
interface rename_freelist_if #(
    parameter int unsigned RENAME_WIDTH = 4,
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned NUM_PREG     = 64,
    parameter int unsigned NUM_AREG     = 32
);
    localparam int unsigned DEPTH  = NUM_PREG - NUM_AREG;
    localparam int unsigned PREG_W = $clog2(NUM_PREG);
    localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;

    logic                                     i_alloc_vld;
    logic [RENAME_WIDTH-1:0]                  i_alloc_req;
    logic                                     o_alloc_rdy;
    logic [RENAME_WIDTH-1:0][PREG_W-1:0]      o_alloc_preg;
    logic [COMMIT_WIDTH-1:0]                  i_commit_vld;
    logic [COMMIT_WIDTH-1:0][PREG_W-1:0]      i_commit_oldpreg;
    logic                                     i_squash;
    logic [PTR_W-1:0]                         o_free_cnt;

    modport master (
        output i_alloc_vld, i_alloc_req, i_commit_vld, i_commit_oldpreg, i_squash,
        input  o_alloc_rdy, o_alloc_preg, o_free_cnt
    );

    modport slave (
        input  i_alloc_vld, i_alloc_req, i_commit_vld, i_commit_oldpreg, i_squash,
        output o_alloc_rdy, o_alloc_preg, o_free_cnt
    );
endinterface

// File: rtl/rename_freelist.sv
// Physical-register free list: circular buffer with speculative head, committed head and tail.
// Grants are combinational from registered state; releases become visible the following cycle.
module rename_freelist #(
    parameter int unsigned RENAME_WIDTH = 4,
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned NUM_PREG     = 64,
    parameter int unsigned NUM_AREG     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    rename_freelist_if.slave      bus
);
    localparam int unsigned DEPTH  = NUM_PREG - NUM_AREG;
    localparam int unsigned PREG_W = $clog2(NUM_PREG);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned RCNT_W = $clog2(RENAME_WIDTH + 1);
    localparam int unsigned CCNT_W = $clog2(COMMIT_WIDTH + 1);

    if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("rename_freelist: NUM_PREG-NUM_AREG must be a non-zero power of two");
    end

    logic [PREG_W-1:0]                    fl [DEPTH];
    logic [PTR_W-1:0]                     spec_head, cmt_head, tail;
    logic [PTR_W-1:0]                     spec_nxt, cmt_nxt, tail_nxt, free_cnt;
    logic [RCNT_W-1:0]                    n_req;
    logic [RENAME_WIDTH-1:0][RCNT_W-1:0]  req_pre;
    logic [CCNT_W-1:0]                    n_cmt;
    logic [COMMIT_WIDTH-1:0][IDX_W-1:0]   wr_idx;
    logic                                 rdy, fire;

    // Lane-order compaction of requests: each requesting lane takes the next free slot.
    always_comb begin
        n_req   = '0;
        req_pre = '0;
        for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            req_pre[k] = n_req;
            n_req      = n_req + RCNT_W'(bus.i_alloc_req[k]);
        end
    end

    always_comb begin
        bus.o_alloc_preg = '0;
        for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            bus.o_alloc_preg[k] = fl[IDX_W'(spec_head[IDX_W-1:0] + IDX_W'(req_pre[k]))];
        end
    end

    // Released pregs are packed behind the tail in lane order.
    always_comb begin
        n_cmt  = '0;
        wr_idx = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            wr_idx[k] = IDX_W'(tail[IDX_W-1:0] + IDX_W'(n_cmt));
            n_cmt     = n_cmt + CCNT_W'(bus.i_commit_vld[k]);
        end
    end

    assign free_cnt       = tail - spec_head;
    assign rdy            = !bus.i_squash && (32'(free_cnt) >= 32'(n_req));
    assign fire           = bus.i_alloc_vld && rdy;
    assign bus.o_alloc_rdy = rdy;
    assign bus.o_free_cnt  = free_cnt;

    // Squash rewinds to the committed head after this cycle's commits are applied.
    always_comb begin
        tail_nxt = tail + PTR_W'(n_cmt);
        cmt_nxt  = cmt_head + PTR_W'(n_cmt);
        spec_nxt = spec_head;
        if (bus.i_squash) begin
            spec_nxt = cmt_nxt;
        end else if (fire) begin
            spec_nxt = spec_head + PTR_W'(n_req);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_head <= '0;
            cmt_head  <= '0;
            tail      <= PTR_W'(DEPTH);
        end else begin
            spec_head <= spec_nxt;
            cmt_head  <= cmt_nxt;
            tail      <= tail_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fl[i] <= PREG_W'(NUM_AREG + i);
            end
        end else begin
            for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
                if (bus.i_commit_vld[k]) begin
                    fl[wr_idx[k]] <= bus.i_commit_oldpreg[k];
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (PTR_W'(tail - cmt_head) <= PTR_W'(DEPTH)));
    a_cmt_behind_spec: assert property (@(posedge clk) disable iff (!rst)
        (PTR_W'(spec_head - cmt_head) <= PTR_W'(DEPTH)));
    a_fire_in_range: assert property (@(posedge clk) disable iff (!rst)
        !(fire && (32'(n_req) > 32'(free_cnt))));
endmodule
